clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
Programmable integer clock divider. It is the parametrised successor to the fixed divide-by-2 toggle flop. It produces a registered divided-clock enable/waveform (clk_out) and a one-cycle period strobe (tick) for any runtime divisor N >= 2. The divisor can be reloaded glitch-free at period boundaries. It sits in the clocking/timebase area and feeds downstream blocks as a clock-enable source; it does not feed any clock tree directly.

Parameters:
WIDTH, 8, bit width of the divisor and the internal counter (max N = 2^WIDTH - 1)
DEFAULT_DIV, 2, divisor loaded on reset; must be in the range 2 to 2^WIDTH-1

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
en  input  1  run enable; 1 = count, 0 = stop and park outputs
div_in  input  WIDTH  new divisor value
div_load  input  1  one-cycle request to load div_in
clk_out  output  1  divided waveform, registered
tick  output  1  one-cycle pulse in the last cycle of each output period, registered
div_active  output  WIDTH  divisor currently in use
div_pend  output  1  a validated divisor is waiting for the next period boundary
cfg_err  output  1  one-cycle pulse: the load was rejected because div_in < 2

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high. rst has priority over everything else.
- Values on reset:
  - cnt = 0, running = 0
  - clk_out = 0, tick = 0, cfg_err = 0
  - div_active = DEFAULT_DIV
  - div_pend = 0, pending register = 0
- Internal counter cnt: WIDTH bits, range 0..N-1, where N = div_active. H = ceil(N/2) = (N+1)>>1, computed at WIDTH+1 bits so there is no overflow.
- Running state (en = 1 and running = 1):
  - next_cnt = (cnt == N-1) ? 0 : cnt+1
- Start (en = 1 and running = 0):
  - next_cnt = 0, running <= 1
- Stop (en = 0):
  - running <= 0, cnt <= 0, clk_out <= 0, tick <= 0
  - The divisor and pending state are kept.
- Registered outputs, updated on every edge while en = 1:
  - clk_out <= (next_cnt < H)
  - tick <= (next_cnt == N-1)
- Waveform:
  - clk_out is high for H cycles, then low for N-H cycles.
  - Even N gives 50% duty. Odd N is high one cycle longer than low.
  - The first output cycle after start is high.
  - For N = 2 the output is 1,0,1,0... and tick is high in every cycle where clk_out = 0.
- Divisor load, when div_load = 1:
  - div_in < 2: rejected. cfg_err <= 1 for one cycle. Divisor and pending state are unchanged.
  - Valid and running = 0 (or en = 0): div_active <= div_in at this edge. No pending state.
  - Valid and running: pending register <= div_in, div_pend <= 1. A second load before the boundary overwrites the pending value (last wins).
- Period boundary: the edge where cnt == N-1 and en = 1.
  - If div_pend = 1: div_active <= pending register and div_pend <= 0.
  - The period that starts with cnt = 0 uses the new N, including for clk_out and tick.
  - If div_load with a valid value coincides with the boundary edge, div_in goes straight to div_active and div_pend stays 0.
- No glitches: the current period always completes with the old N. clk_out never shows a partial high or low phase across a reload.
- en dropping mid-period: the current period is abandoned and the outputs park at 0 on the next edge. A pending divisor then applies immediately, since running = 0.
- rst mid-operation: all state returns to its reset value on that edge, and any pending divisor is discarded.
- tick and clk_out are never X after reset. div_active never holds a value below 2.

Test Plan:
- Reset, then en = 1 with DEFAULT_DIV = 2 -> clk_out = 1,0,1,0 from the first edge after en. tick = 0,1,0,1. div_active = 2.
- Load 3 while idle, then en = 1 -> clk_out repeats 1,1,0. tick is high only in the third cycle of each period. 20 cycles give exactly 6 tick pulses.
- Load 5 while idle, then run -> clk_out = 1,1,1,0,0 repeating. Then load 6 mid-period -> div_pend = 1 until the boundary. The old 5-cycle period completes, then clk_out = 1,1,1,0,0,0 and div_pend = 0.
- div_load with div_in = 1, then with div_in = 0 -> cfg_err pulses for one cycle each time. div_active is unchanged and the waveform is unaffected.
- Two loads (7, then 4) within one period -> only 4 is applied at the boundary. A load coinciding with the cnt == N-1 edge is applied on that edge with no pend.
- rst asserted mid-period with a pending value of 9 -> next edge gives clk_out = 0, tick = 0, div_active = DEFAULT_DIV, div_pend = 0. With en held at 1 after reset, the waveform restarts high. en = 0 mid-period -> outputs are 0 on the next edge and restart high when en = 1.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: registered divided waveform plus a
// one-cycle end-of-period strobe, with divisor reloads deferred to period boundaries.
module clk_div_prog #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   output logic             clk_out,
   output logic             tick,
   output logic [WIDTH-1:0] div_active,
   output logic             div_pend,
   output logic             cfg_err
);

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] pend_val_q, pend_val_d;
   logic             pend_q, pend_d;
   logic             running_q, running_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             cfg_err_q, cfg_err_d;

   logic             load_ok;
   logic             boundary;
   logic [WIDTH-1:0] next_cnt;
   logic [WIDTH:0]   half;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      cnt_d      = cnt_q;
      div_d      = div_q;
      pend_val_d = pend_val_q;
      pend_d     = pend_q;
      running_d  = running_q;
      clk_out_d  = clk_out_q;
      tick_d     = tick_q;
      next_cnt   = '0;
      half       = '0;

      load_ok   = div_load && (div_in >= MIN_DIV);
      cfg_err_d = div_load && (div_in < MIN_DIV);
      boundary  = en && running_q && (cnt_q == div_q - 1'b1);

      // The current period always finishes with the old divisor; new values wait
      // in the pending register unless the counter is idle or at its last cycle.
      if (load_ok) begin
         if (!running_q || !en || boundary) begin
            div_d  = div_in;
            pend_d = 1'b0;
         end else begin
            pend_val_d = div_in;
            pend_d     = 1'b1;
         end
      end else if (pend_q && (!running_q || boundary)) begin
         div_d  = pend_val_q;
         pend_d = 1'b0;
      end

      if (!en) begin
         running_d = 1'b0;
         cnt_d     = '0;
         clk_out_d = 1'b0;
         tick_d    = 1'b0;
      end else begin
         running_d = 1'b1;
         next_cnt  = (running_q && !boundary) ? cnt_q + 1'b1 : '0;
         cnt_d     = next_cnt;
         // Outputs look ahead at the divisor of the period next_cnt belongs to.
         half      = ({1'b0, div_d} + 1'b1) >> 1;
         clk_out_d = ({1'b0, next_cnt} < half);
         tick_d    = (next_cnt == div_d - 1'b1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         div_q      <= DEF_DIV;
         pend_val_q <= '0;
         pend_q     <= 1'b0;
         running_q  <= 1'b0;
         clk_out_q  <= 1'b0;
         tick_q     <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         pend_val_q <= pend_val_d;
         pend_q     <= pend_d;
         running_q  <= running_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign clk_out    = clk_out_q;
   assign tick       = tick_q;
   assign div_active = div_q;
   assign div_pend   = pend_q;
   assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: per-cycle vector table plus a tick-count
// sequence and a bounded wait for the period strobe.
module tb_clk_div_prog;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst, en, div_load;
   logic [WIDTH-1:0] div_in;
   logic             clk_out, tick, div_pend, cfg_err;
   logic [WIDTH-1:0] div_active;

   int total = 0;
   int bad   = 0;

   clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .div_in     (div_in),
      .div_load   (div_load),
      .clk_out    (clk_out),
      .tick       (tick),
      .div_active (div_active),
      .div_pend   (div_pend),
      .cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             rst;
      logic             en;
      logic             ld;
      logic [WIDTH-1:0] din;
      logic             clk_o;
      logic             tick_o;
      logic [WIDTH-1:0] act;
      logic             pend;
      logic             err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic e, input logic l,
                               input int d, input logic co, input logic t,
                               input int a, input logic p, input logic er);
      vec_t v;
      v.rst = r; v.en = e; v.ld = l; v.din = WIDTH'(d);
      v.clk_o = co; v.tick_o = t; v.act = WIDTH'(a); v.pend = p; v.err = er;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs are driven 1 time unit after a rising edge; results are checked 1 unit after the next one.
   task automatic apply_vec(input vec_t v, input int idx);
      rst = v.rst; en = v.en; div_load = v.ld; div_in = v.din;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.clk_out", idx),    32'(clk_out),    32'(v.clk_o));
      check($sformatf("v%0d.tick", idx),       32'(tick),       32'(v.tick_o));
      check($sformatf("v%0d.div_active", idx), 32'(div_active), 32'(v.act));
      check($sformatf("v%0d.div_pend", idx),   32'(div_pend),   32'(v.pend));
      check($sformatf("v%0d.cfg_err", idx),    32'(cfg_err),    32'(v.err));
   endtask

   initial begin
      int ticks;
      bit seen;

      rst = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0;

      // reset, then N=2 from the first enabled edge
      vecs.push_back(mk(1,0,0,0, 0,0,2,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,2,0,0));
      vecs.push_back(mk(0,1,0,0, 0,1,2,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,2,0,0));
      vecs.push_back(mk(0,1,0,0, 0,1,2,0,0));
      // stop, idle load of 3, run 1,1,0
      vecs.push_back(mk(0,0,0,0, 0,0,2,0,0));
      vecs.push_back(mk(0,0,1,3, 0,0,3,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,3,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,3,0,0));
      vecs.push_back(mk(0,1,0,0, 0,1,3,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,3,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,3,0,0));
      vecs.push_back(mk(0,1,0,0, 0,1,3,0,0));
      // rejected loads (1 then 0) leave waveform and divisor alone
      vecs.push_back(mk(0,1,1,1, 1,0,3,0,1));
      vecs.push_back(mk(0,1,1,0, 1,0,3,0,1));
      vecs.push_back(mk(0,1,0,0, 0,1,3,0,0));
      // load 5 while stopping, run 1,1,1,0,0
      vecs.push_back(mk(0,0,1,5, 0,0,5,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,5,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,5,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,5,0,0));
      vecs.push_back(mk(0,1,0,0, 0,0,5,0,0));
      vecs.push_back(mk(0,1,0,0, 0,1,5,0,0));
      // load 6 mid-period: old period completes, then 1,1,1,0,0,0
      vecs.push_back(mk(0,1,0,0, 1,0,5,0,0));
      vecs.push_back(mk(0,1,1,6, 1,0,5,1,0));
      vecs.push_back(mk(0,1,0,0, 1,0,5,1,0));
      vecs.push_back(mk(0,1,0,0, 0,0,5,1,0));
      vecs.push_back(mk(0,1,0,0, 0,1,5,1,0));
      vecs.push_back(mk(0,1,0,0, 1,0,6,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,6,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,6,0,0));
      vecs.push_back(mk(0,1,0,0, 0,0,6,0,0));
      vecs.push_back(mk(0,1,0,0, 0,0,6,0,0));
      vecs.push_back(mk(0,1,0,0, 0,1,6,0,0));
      // loads 7 then 4 in one period: only 4 lands
      vecs.push_back(mk(0,1,0,0, 1,0,6,0,0));
      vecs.push_back(mk(0,1,1,7, 1,0,6,1,0));
      vecs.push_back(mk(0,1,1,4, 1,0,6,1,0));
      vecs.push_back(mk(0,1,0,0, 0,0,6,1,0));
      vecs.push_back(mk(0,1,0,0, 0,0,6,1,0));
      vecs.push_back(mk(0,1,0,0, 0,1,6,1,0));
      vecs.push_back(mk(0,1,0,0, 1,0,4,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,4,0,0));
      vecs.push_back(mk(0,1,0,0, 0,0,4,0,0));
      vecs.push_back(mk(0,1,0,0, 0,1,4,0,0));
      // load 3 on the boundary edge: direct, no pend
      vecs.push_back(mk(0,1,1,3, 1,0,3,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,3,0,0));
      vecs.push_back(mk(0,1,0,0, 0,1,3,0,0));
      // pending 9 discarded by reset, restart high with en held
      vecs.push_back(mk(0,1,0,0, 1,0,3,0,0));
      vecs.push_back(mk(0,1,1,9, 1,0,3,1,0));
      vecs.push_back(mk(1,1,0,0, 0,0,2,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,2,0,0));
      vecs.push_back(mk(0,1,0,0, 0,1,2,0,0));
      // pending 5 then en drop: parks, pending applies once idle
      vecs.push_back(mk(0,1,0,0, 1,0,2,0,0));
      vecs.push_back(mk(0,1,1,5, 0,1,2,1,0));
      vecs.push_back(mk(0,0,0,0, 0,0,2,1,0));
      vecs.push_back(mk(0,0,0,0, 0,0,5,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,5,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,5,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,5,0,0));
      vecs.push_back(mk(0,1,0,0, 0,0,5,0,0));
      vecs.push_back(mk(0,1,0,0, 0,1,5,0,0));
      // en dropped mid-period, then restart high
      vecs.push_back(mk(0,1,0,0, 1,0,5,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,5,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,5,0,0));
      vecs.push_back(mk(0,1,0,0, 1,0,5,0,0));

      @(posedge clk);
      #1;
      foreach (vecs[i]) apply_vec(vecs[i], i);

      // idle load of 3, then 20 enabled cycles must give 1,1,0 repeating and 6 ticks
      en = 1'b0; div_load = 1'b1; div_in = 8'd3;
      @(posedge clk);
      #1;
      check("idle_load3.div_active", 32'(div_active), 32'd3);
      div_load = 1'b0; en = 1'b1;
      ticks = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("n3.clk_out[%0d]", i), 32'(clk_out), 32'((i % 3) < 2));
         if (tick === 1'b1) ticks++;
      end
      check("n3.tick_count", 32'(ticks), 32'd6);

      // bounded wait for the next strobe (cycle 20 is mid-period; due within 2)
      seen = 1'b0;
      for (int i = 0; i < 5 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (tick === 1'b1) seen = 1'b1;
      end
      check("n3.tick_within_budget", 32'(seen), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
